// File: rtl/eth_report_tx_if.sv
// Request and AXI-Stream signals of the report transmitter, bundled.
// The "master" modport is the transmitter's view; "slave" is the environment's
// view (request source plus downstream MAC).
interface eth_report_tx_if #(
  parameter int KEY_SIZE = 96
);
  // Handshakes: a transfer happens on a rising clk156 edge where valid and
  // ready are both 1. Valid, and the payload that goes with it, stay stable
  // until that transfer. Ready may change freely.
  logic                req_valid;
  logic                req_ready;
  logic [KEY_SIZE-1:0] req_key;
  logic [3:0]          req_flag;

  logic                m_axis_tready;
  logic                m_axis_tvalid;
  logic [63:0]         m_axis_tdata;
  logic [7:0]          m_axis_tkeep;
  logic                m_axis_tlast;
  logic                m_axis_tuser;

  modport master (
    input  req_valid, req_key, req_flag, m_axis_tready,
    output req_ready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep,
           m_axis_tlast, m_axis_tuser
  );

  modport slave (
    output req_valid, req_key, req_flag, m_axis_tready,
    input  req_ready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep,
           m_axis_tlast, m_axis_tuser
  );
endinterface

// File: rtl/eth_report_tx.sv
// Report frame transmitter: for each accepted request (key + flag) emit one
// fixed 60-byte Ethernet/IPv4/UDP frame on a 64-bit AXI-Stream. The IPv4 header
// checksum is computed per frame, and each frame carries a 16-bit sequence
// number.
module eth_report_tx #(
  parameter int          KEY_SIZE     = 96,
  parameter logic [47:0] SRC_MAC      = 48'h0022_3344_5566,
  parameter logic [47:0] DST_MAC      = 48'h90e2_ba5d_91d1,
  parameter logic [31:0] SRC_IP       = 32'hc0a8_0164,
  parameter logic [31:0] DST_IP       = 32'hc0a8_0162,
  parameter logic [15:0] UDP_SRC_PORT = 16'd12345,
  parameter logic [15:0] UDP_DST_PORT = 16'd12345
) (
  input  logic                  clk156,
  input  logic                  eth_rst,
  eth_report_tx_if.master       bus,
  output logic [15:0]           tx_seq,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CSUM_ADD  = 2'd1,
    CSUM_FOLD = 2'd2,
    SEND      = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          beat_q, beat_d;
  logic [KEY_SIZE-1:0] key_q;
  logic [3:0]          flag_q;
  logic [15:0]         seq_l_q;
  logic [19:0]         sum_q;
  logic [15:0]         csum_q;
  logic [15:0]         tx_seq_q;

  logic                accept;
  logic                beat_fire;
  logic [16:0]         fold1;
  logic [15:0]         fold2;
  logic [479:0]        frame_be;
  logic [511:0]        frame_le;

  // Ready only in IDLE, and never while reset is asserted, so reset always
  // wins over a simultaneous request.
  assign bus.req_ready = (state_q == IDLE) && !eth_rst;
  assign accept        = bus.req_valid && bus.req_ready;
  assign beat_fire     = (state_q == SEND) && bus.m_axis_tready;
  assign tx_seq        = tx_seq_q;
  assign state_dbg     = state_q;

  // Ones-complement fold of the 20-bit header sum; the second fold absorbs a
  // carry produced by the first.
  always_comb begin
    fold1 = {1'b0, sum_q[15:0]} + {13'h0, sum_q[19:16]};
    fold2 = fold1[15:0] + {15'h0, fold1[16]};
  end

  // Whole frame in network byte order, then byte-reversed so that frame
  // byte n lands in bits [8n+7:8n] and a beat is a straight 64-bit slice.
  always_comb begin
    frame_be = {DST_MAC, SRC_MAC, 16'h0800,
                8'h45, 8'h00, 16'h002E, seq_l_q, 16'h4000, 8'h40, 8'h11,
                csum_q, SRC_IP, DST_IP,
                UDP_SRC_PORT, UDP_DST_PORT, 16'h001A, 16'h0000,
                seq_l_q, {4'h0, flag_q}, 8'h00, key_q, 16'h0000};
    frame_le = '0;
    for (int n = 0; n < 60; n++) begin
      frame_le[8*n +: 8] = frame_be[479-8*n -: 8];
    end
  end

  // State register, request latch, checksum pipeline and sequence counter.
  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      state_q  <= IDLE;
      beat_q   <= 3'd0;
      key_q    <= '0;
      flag_q   <= 4'h0;
      seq_l_q  <= 16'h0;
      sum_q    <= 20'h0;
      csum_q   <= 16'h0;
      tx_seq_q <= 16'h0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (accept) begin
        key_q   <= bus.req_key;
        flag_q  <= bus.req_flag;
        seq_l_q <= tx_seq_q;
      end
      if (state_q == CSUM_ADD) begin
        // Ten header words, checksum field counted as zero.
        sum_q <= 20'h04500 + 20'h0002E + {4'h0, seq_l_q} + 20'h04000
               + 20'h04011 + 20'h00000
               + {4'h0, SRC_IP[31:16]} + {4'h0, SRC_IP[15:0]}
               + {4'h0, DST_IP[31:16]} + {4'h0, DST_IP[15:0]};
      end
      if (state_q == CSUM_FOLD) begin
        csum_q <= ~fold2;
      end
      if (beat_fire && (beat_q == 3'd7)) begin
        tx_seq_q <= tx_seq_q + 16'd1;
      end
    end
  end

  // Next-state logic: accept, two checksum cycles, then eight beats.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = CSUM_ADD;
      end
      CSUM_ADD: begin
        state_d = CSUM_FOLD;
      end
      CSUM_FOLD: begin
        state_d = SEND;
        beat_d  = 3'd0;
      end
      SEND: begin
        if (beat_fire) begin
          if (beat_q == 3'd7) begin
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stream outputs depend only on state and beat, so they hold while stalled.
  always_comb begin
    bus.m_axis_tvalid = 1'b0;
    bus.m_axis_tdata  = 64'h0;
    bus.m_axis_tkeep  = 8'h00;
    bus.m_axis_tlast  = 1'b0;
    bus.m_axis_tuser  = 1'b0;
    if (state_q == SEND) begin
      bus.m_axis_tvalid = 1'b1;
      bus.m_axis_tdata  = frame_le[{beat_q, 6'b0} +: 64];
      bus.m_axis_tkeep  = (beat_q == 3'd7) ? 8'h0F : 8'hFF;
      bus.m_axis_tlast  = (beat_q == 3'd7);
    end
  end

endmodule

// File: tb/tb_eth_report_tx.sv
// Directed bench for eth_report_tx: reset state, frame contents and latency,
// checksum per sequence number, random back-pressure, sequence wrap, reset in
// mid-frame, and back-to-back requests.
module tb_eth_report_tx;
  logic        clk156;
  logic        eth_rst;
  logic [15:0] tx_seq;
  logic [1:0]  state_dbg;

  eth_report_tx_if #(.KEY_SIZE(96)) bus();

  eth_report_tx dut (
    .clk156    (clk156),
    .eth_rst   (eth_rst),
    .bus       (bus),
    .tx_seq    (tx_seq),
    .state_dbg (state_dbg)
  );

  localparam logic [95:0] KEY1 = 96'hc0a80164_c0a80162_3039_0000;
  localparam logic [95:0] KEY2 = 96'h0a000001_0a000002_0035_1234;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] cap_data [24];
  logic [7:0]  cap_keep [24];
  logic        cap_last [24];
  int          cap_wait;
  int          cap_cycles;
  int          stall_err;

  // Clock and reset
  initial clk156 = 1'b0;
  always #3 clk156 = ~clk156;

  // Expected beat, written out lane by lane (lane 0 = lowest byte).
  function automatic logic [63:0] exp_beat(input int b, input logic [15:0] seq,
                                            input logic [15:0] csum,
                                            input logic [95:0] key,
                                            input logic [3:0] flag);
    logic [7:0] k [12];
    for (int i = 0; i < 12; i++) k[i] = key[95-8*i -: 8];
    case (b)
      0: return 64'h2200_d191_5dba_e290;
      1: return 64'h0045_0008_6655_4433;
      2: return {8'h11, 8'h40, 8'h00, 8'h40, seq[7:0], seq[15:8], 8'h2E, 8'h00};
      3: return {8'hA8, 8'hC0, 8'h64, 8'h01, 8'hA8, 8'hC0, csum[7:0], csum[15:8]};
      4: return 64'h1A00_3930_3930_6201;
      5: return {k[1], k[0], 8'h00, {4'h0, flag}, seq[7:0], seq[15:8], 8'h00, 8'h00};
      6: return {k[9], k[8], k[7], k[6], k[5], k[4], k[3], k[2]};
      default: return {32'h0, 8'h00, 8'h00, k[11], k[10]};
    endcase
  endfunction

  // Driver: present a request and hold it until accepted.
  task automatic send_req(input logic [95:0] key, input logic [3:0] flag);
    int w;
    @(negedge clk156);
    bus.req_key   = key;
    bus.req_flag  = flag;
    bus.req_valid = 1'b1;
    w = 0;
    while (!bus.req_ready && w < 100) begin
      @(negedge clk156);
      w++;
    end
    if (!bus.req_ready) begin
      n_tests++; n_fail++;
      $display("FAIL req_accept_timeout: req_ready=%0b after %0d cycles, need 1", bus.req_ready, w);
      bus.req_valid = 1'b0;
    end else begin
      @(posedge clk156);
      #1 bus.req_valid = 1'b0;
    end
  endtask

  // Driver/monitor: collect 8 accepted beats into cap_* starting at base.
  task automatic recv_frame(input int base, input bit rnd);
    int got, cyc;
    bit seen, pend;
    logic [63:0] pd;
    logic [7:0]  pk;
    logic        pl;
    got = 0; cyc = 0; seen = 0; pend = 0;
    pd = '0; pk = '0; pl = 1'b0;
    cap_wait = 0;
    while (got < 8 && cyc < 300) begin
      @(negedge clk156);
      cyc++;
      if (pend && (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== pd ||
                   bus.m_axis_tkeep !== pk || bus.m_axis_tlast !== pl))
        stall_err++;
      if (bus.m_axis_tvalid) seen = 1;
      else if (!seen) cap_wait++;
      bus.m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        cap_data[base+got] = bus.m_axis_tdata;
        cap_keep[base+got] = bus.m_axis_tkeep;
        cap_last[base+got] = bus.m_axis_tlast;
        got++;
        pend = 0;
      end else begin
        pend = bus.m_axis_tvalid;
        pd = bus.m_axis_tdata; pk = bus.m_axis_tkeep; pl = bus.m_axis_tlast;
      end
    end
    cap_cycles = cyc - cap_wait;
    if (got < 8) begin
      n_tests++; n_fail++;
      $display("FAIL frame_timeout: got %0d beats, need 8", got);
    end
    bus.m_axis_tready = 1'b1;
  endtask

  task automatic test_reset();
    eth_rst = 1'b1;
    repeat (3) @(negedge clk156);
    n_tests++;
    if (bus.m_axis_tvalid !== 1'b0 || bus.m_axis_tlast !== 1'b0 ||
        bus.m_axis_tkeep !== 8'h00 || bus.m_axis_tdata !== 64'h0 ||
        bus.m_axis_tuser !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_axis: tvalid=%0b tlast=%0b tkeep=%h tdata=%h tuser=%0b, need all 0",
               bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata, bus.m_axis_tuser);
    end
    n_tests++;
    if (tx_seq !== 16'h0 || bus.req_ready !== 1'b0 || state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: tx_seq=%h req_ready=%0b state=%0d, need 0/0/0", tx_seq, bus.req_ready, state_dbg);
    end
    eth_rst = 1'b0;
    @(negedge clk156);
    n_tests++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: req_ready=%0b, need 1", bus.req_ready);
    end
  endtask

  task automatic test_first_frame();
    stall_err = 0;
    send_req(KEY1, 4'b0101);
    recv_frame(0, 1'b0);
    n_tests++;
    if (cap_wait + 1 !== 3) begin
      n_fail++;
      $display("FAIL first_beat_latency: %0d cycles, need 3", cap_wait + 1);
    end
    n_tests++;
    if (cap_cycles !== 8) begin
      n_fail++;
      $display("FAIL frame_cycles: %0d, need 8", cap_cycles);
    end
    for (int b = 0; b < 8; b++) begin
      n_tests++;
      if (cap_data[b] !== exp_beat(b, 16'h0000, 16'hB6A8, KEY1, 4'b0101) ||
          cap_keep[b] !== ((b == 7) ? 8'h0F : 8'hFF) || cap_last[b] !== (b == 7)) begin
        n_fail++;
        $display("FAIL frame0_beat%0d: data=%h keep=%h last=%0b, need data=%h keep=%h last=%0b",
                 b, cap_data[b], cap_keep[b], cap_last[b],
                 exp_beat(b, 16'h0000, 16'hB6A8, KEY1, 4'b0101), (b == 7) ? 8'h0F : 8'hFF, b == 7);
      end
    end
    @(negedge clk156);
    n_tests++;
    if (tx_seq !== 16'h0001 || bus.m_axis_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL frame0_end: tx_seq=%h tvalid=%0b, need 0001/0", tx_seq, bus.m_axis_tvalid);
    end
  endtask

  task automatic test_checksum();
    send_req(KEY2, 4'hA);
    recv_frame(0, 1'b0);
    n_tests++;
    if (cap_data[3][15:0] !== 16'hA7B6) begin
      n_fail++;
      $display("FAIL csum_seq1: bytes24-25 lanes=%h, need a7b6", cap_data[3][15:0]);
    end
    for (int b = 0; b < 8; b++) begin
      n_tests++;
      if (cap_data[b] !== exp_beat(b, 16'h0001, 16'hB6A7, KEY2, 4'hA)) begin
        n_fail++;
        $display("FAIL frame1_beat%0d: data=%h, need %h", b, cap_data[b],
                 exp_beat(b, 16'h0001, 16'hB6A7, KEY2, 4'hA));
      end
    end
    @(negedge clk156);
    n_tests++;
    if (tx_seq !== 16'h0002) begin
      n_fail++;
      $display("FAIL seq_after_frame1: tx_seq=%h, need 0002", tx_seq);
    end
  endtask

  task automatic test_random_stall();
    logic [15:0] csums [3];
    csums[0] = 16'hB6A8; csums[1] = 16'hB6A7; csums[2] = 16'hB6A6;
    @(negedge clk156);
    eth_rst = 1'b1;
    @(negedge clk156);
    n_tests++;
    if (tx_seq !== 16'h0) begin
      n_fail++;
      $display("FAIL seq_reset: tx_seq=%h, need 0000", tx_seq);
    end
    eth_rst = 1'b0;
    stall_err = 0;
    fork
      begin
        for (int f = 0; f < 3; f++) send_req(KEY1, 4'b0101);
      end
      begin
        for (int f = 0; f < 3; f++) recv_frame(8*f, 1'b1);
      end
    join
    for (int i = 0; i < 24; i++) begin
      n_tests++;
      if (cap_data[i] !== exp_beat(i % 8, 16'(i / 8), csums[i / 8], KEY1, 4'b0101) ||
          cap_last[i] !== ((i % 8) == 7)) begin
        n_fail++;
        $display("FAIL stall_beat%0d: data=%h last=%0b, need %h/%0b", i, cap_data[i], cap_last[i],
                 exp_beat(i % 8, 16'(i / 8), csums[i / 8], KEY1, 4'b0101), (i % 8) == 7);
      end
    end
    n_tests++;
    if (stall_err !== 0) begin
      n_fail++;
      $display("FAIL stall_stable: %0d changed beats while stalled, need 0", stall_err);
    end
    @(negedge clk156);
    n_tests++;
    if (tx_seq !== 16'h0003) begin
      n_fail++;
      $display("FAIL seq_after_stall: tx_seq=%h, need 0003", tx_seq);
    end
  endtask

  task automatic test_seq_wrap();
    @(negedge clk156);
    force dut.tx_seq_q = 16'hFFFF;
    @(negedge clk156);
    release dut.tx_seq_q;
    @(negedge clk156);
    n_tests++;
    if (tx_seq !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL seq_preload: tx_seq=%h, need ffff", tx_seq);
    end
    send_req(KEY1, 4'b0101);
    recv_frame(0, 1'b0);
    for (int b = 0; b < 8; b++) begin
      n_tests++;
      if (cap_data[b] !== exp_beat(b, 16'hFFFF, 16'hB6A8, KEY1, 4'b0101)) begin
        n_fail++;
        $display("FAIL wrap_beat%0d: data=%h, need %h", b, cap_data[b],
                 exp_beat(b, 16'hFFFF, 16'hB6A8, KEY1, 4'b0101));
      end
    end
    @(negedge clk156);
    n_tests++;
    if (tx_seq !== 16'h0000) begin
      n_fail++;
      $display("FAIL seq_wrap: tx_seq=%h, need 0000", tx_seq);
    end
  endtask

  task automatic test_reset_mid_frame();
    int got, cyc;
    send_req(KEY1, 4'b0101);
    bus.m_axis_tready = 1'b1;
    got = 0; cyc = 0;
    while (got < 4 && cyc < 50) begin
      @(negedge clk156);
      cyc++;
      if (bus.m_axis_tvalid) got++;
    end
    @(negedge clk156);
    n_tests++;
    if (bus.m_axis_tdata !== exp_beat(4, 16'h0000, 16'hB6A8, KEY1, 4'b0101)) begin
      n_fail++;
      $display("FAIL mid_beat4: data=%h, need %h", bus.m_axis_tdata,
               exp_beat(4, 16'h0000, 16'hB6A8, KEY1, 4'b0101));
    end
    eth_rst = 1'b1;
    @(negedge clk156);
    n_tests++;
    if (bus.m_axis_tvalid !== 1'b0 || bus.m_axis_tlast !== 1'b0 || tx_seq !== 16'h0 || state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_reset: tvalid=%0b tlast=%0b tx_seq=%h state=%0d, need 0/0/0000/0",
               bus.m_axis_tvalid, bus.m_axis_tlast, tx_seq, state_dbg);
    end
    bus.req_key = KEY2; bus.req_flag = 4'hA; bus.req_valid = 1'b1;
    #1;
    n_tests++;
    if (bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_vs_req_ready: req_ready=%0b, need 0", bus.req_ready);
    end
    @(negedge clk156);
    n_tests++;
    if (state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_vs_req_state: state=%0d, need 0", state_dbg);
    end
    eth_rst = 1'b0;
    bus.req_valid = 1'b0;
    send_req(KEY2, 4'hA);
    recv_frame(0, 1'b0);
    for (int b = 0; b < 8; b++) begin
      n_tests++;
      if (cap_data[b] !== exp_beat(b, 16'h0000, 16'hB6A8, KEY2, 4'hA)) begin
        n_fail++;
        $display("FAIL post_reset_beat%0d: data=%h, need %h", b, cap_data[b],
                 exp_beat(b, 16'h0000, 16'hB6A8, KEY2, 4'hA));
      end
    end
    @(negedge clk156);
    n_tests++;
    if (tx_seq !== 16'h0001) begin
      n_fail++;
      $display("FAIL post_reset_seq: tx_seq=%h, need 0001", tx_seq);
    end
  endtask

  task automatic test_back_to_back();
    int acc, hi, low_run, ng;
    int gaps [4];
    bit seen;
    logic [15:0] csums [3];
    csums[0] = 16'hB6A7; csums[1] = 16'hB6A6; csums[2] = 16'hB6A5;
    acc = 0; hi = 0; low_run = 0; ng = 0; seen = 0;
    for (int i = 0; i < 4; i++) gaps[i] = 0;
    bus.m_axis_tready = 1'b1;
    @(negedge clk156);
    bus.req_key = KEY1; bus.req_flag = 4'b0101; bus.req_valid = 1'b1;
    #1;
    for (int i = 0; i < 33; i++) begin
      if (i > 0) @(negedge clk156);
      if (bus.req_ready) acc++;
      if (bus.m_axis_tvalid) begin
        if (seen && low_run > 0 && ng < 4) begin
          gaps[ng] = low_run;
          ng++;
        end
        low_run = 0;
        seen = 1;
        if (hi < 24) cap_data[hi] = bus.m_axis_tdata;
        hi++;
      end else if (seen) begin
        low_run++;
      end
    end
    bus.req_valid = 1'b0;
    n_tests++;
    if (acc !== 3) begin
      n_fail++;
      $display("FAIL b2b_ready_pulses: %0d, need 3", acc);
    end
    n_tests++;
    if (hi !== 24) begin
      n_fail++;
      $display("FAIL b2b_beats: %0d, need 24", hi);
    end
    n_tests++;
    if (ng !== 2 || gaps[0] !== 3 || gaps[1] !== 3) begin
      n_fail++;
      $display("FAIL b2b_gaps: count=%0d gap0=%0d gap1=%0d, need 2/3/3", ng, gaps[0], gaps[1]);
    end
    for (int i = 0; i < 24; i++) begin
      n_tests++;
      if (cap_data[i] !== exp_beat(i % 8, 16'(1 + i / 8), csums[i / 8], KEY1, 4'b0101)) begin
        n_fail++;
        $display("FAIL b2b_beat%0d: data=%h, need %h", i, cap_data[i],
                 exp_beat(i % 8, 16'(1 + i / 8), csums[i / 8], KEY1, 4'b0101));
      end
    end
    @(negedge clk156);
    n_tests++;
    if (tx_seq !== 16'h0004 || bus.m_axis_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: tx_seq=%h tvalid=%0b, need 0004/0", tx_seq, bus.m_axis_tvalid);
    end
  endtask

  initial begin
    eth_rst           = 1'b1;
    bus.req_valid     = 1'b0;
    bus.req_key       = '0;
    bus.req_flag      = 4'h0;
    bus.m_axis_tready = 1'b1;
    stall_err         = 0;
    test_reset();
    test_first_frame();
    test_checksum();
    test_random_stall();
    test_seq_wrap();
    test_reset_mid_frame();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
